// File: rtl/skut_ram_sched.sv
// Write-port scheduler for the ping-pong telemetry frame RAM: arbitrates the frame former (A)
// and the service writer (B) onto one write port and swaps banks on every frame strobe.
//
// state  | meaning
// IDLE   | no write this cycle
// A_WR   | former word written into the current bank
// B_WR   | service word written, ack pulsed
// SWAP   | bank toggle, frame statistics published, no write
module skut_ram_sched #(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int FRAME_WORDS = 80,
    parameter int B_TIMEOUT   = 15
) (
    input  logic              iClk,
    input  logic              reset,
    input  logic              i8KHz,
    input  logic              iWrEnA,
    input  logic [ADDR_W-1:0] iAddrA,
    input  logic [DATA_W-1:0] iDataA,
    input  logic              iReqB,
    input  logic [ADDR_W-1:0] iAddrB,
    input  logic [DATA_W-1:0] iDataB,
    output logic              oAckB,
    output logic              oRamWe,
    output logic [ADDR_W:0]   oRamAddr,
    output logic [DATA_W-1:0] oRamData,
    output logic              oWrBank,
    output logic              oRdBank,
    output logic              oFrameStart,
    output logic [7:0]        oWordCnt,
    output logic              oFrameErr,
    output logic              oCollision,
    output logic              oStarveB
);
    typedef enum logic [1:0] {IDLE = 2'd0, A_WR = 2'd1, B_WR = 2'd2, SWAP = 2'd3} state_t;

    localparam int                WAIT_W    = $clog2(B_TIMEOUT + 2);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(B_TIMEOUT + 1);
    localparam logic [7:0]        FRAME_CNT = 8'(FRAME_WORDS);

    state_t state_q, state_d;
    logic sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
    logic wra_prev_q, wra_prev_d;
    logic [7:0] run_cnt_q, run_cnt_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic ram_we_q, ram_we_d;
    logic [ADDR_W:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_data_q, ram_data_d;
    logic ack_q, ack_d;
    logic bank_q, bank_d;
    logic rd_bank_q, rd_bank_d;
    logic frame_start_q, frame_start_d;
    logic [7:0] word_cnt_q, word_cnt_d;
    logic frame_err_q, frame_err_d;
    logic collision_q, collision_d;
    logic starve_q, starve_d;
    logic frame_edge, a_rise, grant;

    always_comb begin
        sync1_d    = i8KHz;
        sync2_d    = sync1_q;
        sync3_d    = sync2_q;
        frame_edge = sync2_q & ~sync3_q;
        a_rise     = iWrEnA & ~wra_prev_q;
        wra_prev_d = iWrEnA;

        if (frame_edge)                      state_d = SWAP;
        else if (iWrEnA)                     state_d = A_WR;
        else if (iReqB && state_q != B_WR)   state_d = B_WR;
        else                                 state_d = IDLE;

        ram_we_d      = 1'b0;
        ram_addr_d    = ram_addr_q;
        ram_data_d    = ram_data_q;
        ack_d         = 1'b0;
        bank_d        = bank_q;
        rd_bank_d     = rd_bank_q;
        frame_start_d = 1'b0;
        word_cnt_d    = word_cnt_q;
        frame_err_d   = 1'b0;
        collision_d   = 1'b0;
        run_cnt_d     = (a_rise && run_cnt_q != 8'hFF) ? run_cnt_q + 8'd1 : run_cnt_q;

        case (state_d)
            SWAP: begin
                bank_d        = ~bank_q;
                rd_bank_d     = bank_q;
                frame_start_d = 1'b1;
                word_cnt_d    = run_cnt_q;
                frame_err_d   = (run_cnt_q != FRAME_CNT);
                // a word starting on the swap cycle belongs to the new frame
                run_cnt_d     = {7'd0, a_rise};
                collision_d   = iWrEnA;
            end
            A_WR: begin
                ram_we_d   = 1'b1;
                ram_addr_d = {bank_q, iAddrA};
                ram_data_d = iDataA;
            end
            B_WR: begin
                ram_we_d   = 1'b1;
                ram_addr_d = {bank_q, iAddrB};
                ram_data_d = iDataB;
                ack_d      = 1'b1;
            end
            default: ;
        endcase

        grant = (state_d == B_WR);
        // the cycle showing oAckB still sees the old request held, so it is not a wait cycle
        if (grant || ack_q || !iReqB) wait_d = '0;
        else if (wait_q != WAIT_MAX)  wait_d = wait_q + 1'b1;
        else                          wait_d = wait_q;

        starve_d = grant ? 1'b0 : (starve_q | (wait_d == WAIT_MAX));
    end

    always_ff @(posedge iClk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            sync3_q       <= 1'b0;
            wra_prev_q    <= 1'b0;
            run_cnt_q     <= '0;
            wait_q        <= '0;
            ram_we_q      <= 1'b0;
            ram_addr_q    <= '0;
            ram_data_q    <= '0;
            ack_q         <= 1'b0;
            bank_q        <= 1'b0;
            rd_bank_q     <= 1'b1;
            frame_start_q <= 1'b0;
            word_cnt_q    <= '0;
            frame_err_q   <= 1'b0;
            collision_q   <= 1'b0;
            starve_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            sync3_q       <= sync3_d;
            wra_prev_q    <= wra_prev_d;
            run_cnt_q     <= run_cnt_d;
            wait_q        <= wait_d;
            ram_we_q      <= ram_we_d;
            ram_addr_q    <= ram_addr_d;
            ram_data_q    <= ram_data_d;
            ack_q         <= ack_d;
            bank_q        <= bank_d;
            rd_bank_q     <= rd_bank_d;
            frame_start_q <= frame_start_d;
            word_cnt_q    <= word_cnt_d;
            frame_err_q   <= frame_err_d;
            collision_q   <= collision_d;
            starve_q      <= starve_d;
        end
    end

    assign oRamWe      = ram_we_q;
    assign oRamAddr    = ram_addr_q;
    assign oRamData    = ram_data_q;
    assign oAckB       = ack_q;
    assign oWrBank     = bank_q;
    assign oRdBank     = rd_bank_q;
    assign oFrameStart = frame_start_q;
    assign oWordCnt    = word_cnt_q;
    assign oFrameErr   = frame_err_q;
    assign oCollision  = collision_q;
    assign oStarveB    = starve_q;
endmodule

// File: tb/tb_skut_ram_sched.sv
// Bench for skut_ram_sched: directed frames, contention, starvation, collision and reset,
// with a cycle-level reference model checked on every falling edge.
module tb_skut_ram_sched;
    localparam int FRAME_WORDS = 80;
    localparam int B_TIMEOUT   = 15;

    logic       iClk = 1'b0, reset = 1'b1, i8KHz = 1'b0;
    logic       iWrEnA = 1'b0, iReqB = 1'b0;
    logic [6:0] iAddrA = '0, iAddrB = '0;
    logic [7:0] iDataA = '0, iDataB = '0;
    logic       oAckB, oRamWe, oWrBank, oRdBank, oFrameStart, oFrameErr, oCollision, oStarveB;
    logic [7:0] oRamAddr, oRamData, oWordCnt;

    int n_pass = 0, n_total = 0;

    skut_ram_sched #(.ADDR_W(7), .DATA_W(8), .FRAME_WORDS(FRAME_WORDS), .B_TIMEOUT(B_TIMEOUT)) dut (
        .iClk(iClk), .reset(reset), .i8KHz(i8KHz),
        .iWrEnA(iWrEnA), .iAddrA(iAddrA), .iDataA(iDataA),
        .iReqB(iReqB), .iAddrB(iAddrB), .iDataB(iDataB), .oAckB(oAckB),
        .oRamWe(oRamWe), .oRamAddr(oRamAddr), .oRamData(oRamData),
        .oWrBank(oWrBank), .oRdBank(oRdBank), .oFrameStart(oFrameStart),
        .oWordCnt(oWordCnt), .oFrameErr(oFrameErr), .oCollision(oCollision), .oStarveB(oStarveB)
    );

    always #5 iClk = ~iClk;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // reference model: words are counted per frame as plain integers, the strobe rise is
    // acted on two samples after the bench sees it, B may not win two cycles in a row
    bit [2:0]   s_hist = '0;
    bit         m_bank = 0, m_prev_a = 0, m_granted = 0, m_starve = 0;
    bit         m_swap, m_grant, m_anew;
    int         m_words = 0, m_wait = 0;
    bit         e_we = 0, e_ack = 0, e_fs = 0, e_err = 0, e_coll = 0;
    int         e_cnt = 0;
    logic [7:0] e_addr = '0, e_data = '0;

    always @(posedge iClk or posedge reset) begin
        if (reset) begin
            s_hist = '0; m_bank = 0; m_prev_a = 0; m_granted = 0; m_starve = 0;
            m_words = 0; m_wait = 0;
            e_we = 0; e_ack = 0; e_fs = 0; e_err = 0; e_coll = 0; e_cnt = 0;
        end else begin
            m_swap = s_hist[1] && !s_hist[2];
            s_hist = {s_hist[1:0], i8KHz};
            m_anew = iWrEnA && !m_prev_a;
            m_grant = 0;
            e_we = 0; e_ack = 0; e_fs = 0; e_err = 0; e_coll = 0;
            if (m_swap) begin
                e_fs   = 1;
                e_cnt  = (m_words > 255) ? 255 : m_words;
                e_err  = (m_words != FRAME_WORDS);
                m_words = m_anew ? 1 : 0;
                m_bank = !m_bank;
                e_coll = iWrEnA;
            end else begin
                if (m_anew) m_words++;
                if (iWrEnA) begin
                    e_we = 1; e_addr = {m_bank, iAddrA}; e_data = iDataA;
                end else if (iReqB && !m_granted) begin
                    m_grant = 1; e_we = 1; e_ack = 1; e_addr = {m_bank, iAddrB}; e_data = iDataB;
                end
            end
            if (m_grant || m_granted || !iReqB) m_wait = 0;
            else m_wait++;
            if (m_grant) m_starve = 0;
            else if (m_wait > B_TIMEOUT) m_starve = 1;
            m_granted = m_grant;
            m_prev_a  = iWrEnA;
        end
    end

    always @(negedge iClk) begin
        chk("ram_we", oRamWe, e_we);
        if (e_we) begin
            chk("ram_addr", oRamAddr, e_addr);
            chk("ram_data", oRamData, e_data);
        end
        chk("ack_b", oAckB, e_ack);
        chk("wr_bank", oWrBank, m_bank);
        chk("rd_bank", oRdBank, !m_bank);
        chk("frame_start", oFrameStart, e_fs);
        chk("word_cnt", oWordCnt, e_cnt);
        chk("frame_err", oFrameErr, e_err);
        chk("collision", oCollision, e_coll);
        chk("starve_b", oStarveB, m_starve);
    end

    task automatic a_frame(input int n, input int hold);
        for (int w = 0; w < n; w++) begin
            for (int h = 0; h < hold; h++) begin
                @(negedge iClk);
                iWrEnA = 1'b1; iAddrA = 7'(w); iDataA = 8'(w * 3 + h);
            end
            @(negedge iClk);
            iWrEnA = 1'b0;
        end
    endtask

    task automatic frame_swap(input int len, input int exp_cnt, input int exp_err, input int exp_bank);
        bit seen = 0;
        int lat = 0;
        @(negedge iClk);
        i8KHz = 1'b1;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(negedge iClk);
            if (k == len) i8KHz = 1'b0;
            if (oFrameStart) begin
                seen = 1; lat = k;
                chk("frame_cnt_lit", oWordCnt, exp_cnt);
                chk("frame_err_lit", oFrameErr, exp_err);
                chk("wr_bank_lit", oWrBank, exp_bank);
                chk("rd_bank_lit", oRdBank, 1 - exp_bank);
            end
        end
        i8KHz = 1'b0;
        chk("frame_start_seen", int'(seen), 1);
        chk("frame_latency", lat, 3);
        repeat (2) @(negedge iClk);
    endtask

    task automatic b_write(input logic [6:0] a, input logic [7:0] d, output int waited);
        bit seen = 0;
        waited = 0;
        iReqB = 1'b1; iAddrB = a; iDataB = d;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(negedge iClk);
            waited = k;
            if (oAckB) begin
                seen = 1;
                chk("b_data_lit", oRamData, d);
            end
        end
        chk("b_ack_seen", int'(seen), 1);
    endtask

    initial begin
        int w1, w2;
        repeat (3) @(negedge iClk);
        chk("reset_rd_bank", oRdBank, 1);
        chk("reset_wr_bank", oWrBank, 0);
        chk("reset_we", oRamWe, 0);
        reset = 1'b0;
        repeat (2) @(negedge iClk);

        a_frame(80, 8);
        frame_swap(2, 80, 0, 1);
        a_frame(79, 1);
        frame_swap(1, 79, 1, 0);
        a_frame(300, 1);
        frame_swap(3, 255, 1, 1);

        // contention: B waits out 10 A cycles then wins on the first free cycle
        @(negedge iClk);
        iReqB = 1'b1; iAddrB = 7'd5; iDataB = 8'hA5;
        iWrEnA = 1'b1; iAddrA = 7'd20; iDataA = 8'h01;
        for (int k = 1; k <= 10; k++) begin
            @(negedge iClk);
            chk("contention_no_ack", oAckB, 0);
            iDataA = 8'(k + 1);
        end
        iWrEnA = 1'b0;
        @(negedge iClk);
        chk("contention_ack", oAckB, 1);
        chk("contention_addr", oRamAddr, 8'h85);
        chk("contention_data", oRamData, 8'hA5);
        iReqB = 1'b0;
        repeat (2) @(negedge iClk);

        // starvation: 20 A cycles, flag rises after the 16th waiting cycle
        iReqB = 1'b1; iAddrB = 7'd6; iDataB = 8'h5A;
        iWrEnA = 1'b1; iAddrA = 7'd30;
        for (int k = 1; k <= 20; k++) begin
            @(negedge iClk);
            if (k == 15) chk("starve_before", oStarveB, 0);
            if (k == 16) chk("starve_set", oStarveB, 1);
        end
        iWrEnA = 1'b0;
        @(negedge iClk);
        chk("starve_ack", oAckB, 1);
        chk("starve_cleared", oStarveB, 0);
        iReqB = 1'b0;
        repeat (2) @(negedge iClk);

        // swap collision with the strobe then held high
        i8KHz = 1'b1;
        @(negedge iClk);
        @(negedge iClk);
        iWrEnA = 1'b1; iAddrA = 7'd9; iDataA = 8'h3C;
        @(negedge iClk);
        chk("coll_fs", oFrameStart, 1);
        chk("coll_flag", oCollision, 1);
        chk("coll_we", oRamWe, 0);
        chk("coll_bank", oWrBank, 0);
        chk("coll_cnt", oWordCnt, 2);
        @(negedge iClk);
        iWrEnA = 1'b0;
        chk("coll_next_we", oRamWe, 1);
        chk("coll_next_addr", oRamAddr, 8'h09);
        for (int k = 0; k < 20; k++) begin
            @(negedge iClk);
            chk("held_strobe_no_swap", oFrameStart, 0);
        end
        i8KHz = 1'b0;
        repeat (3) @(negedge iClk);
        frame_swap(1, 1, 1, 1);

        // asynchronous reset in the middle of a write burst
        @(negedge iClk);
        iWrEnA = 1'b1; iAddrA = 7'd40; iDataA = 8'h77;
        repeat (3) @(negedge iClk);
        chk("pre_reset_we", oRamWe, 1);
        @(posedge iClk);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_we", oRamWe, 0);
        chk("async_reset_wr_bank", oWrBank, 0);
        chk("async_reset_rd_bank", oRdBank, 1);
        iWrEnA = 1'b0;
        repeat (2) @(negedge iClk);
        reset = 1'b0;
        repeat (2) @(negedge iClk);
        a_frame(5, 2);
        frame_swap(1, 5, 1, 1);

        // back-to-back B words are at least two cycles apart
        b_write(7'd1, 8'h11, w1);
        b_write(7'd2, 8'h22, w2);
        iReqB = 1'b0;
        chk("b_first_wait", w1, 1);
        chk("b_second_wait", w2, 2);
        repeat (3) @(negedge iClk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end
endmodule
